// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the system bus arbiter: master indices,
// active-low enable levels and the arbiter state encoding.
package bus_arbiter_pkg;

  // Fixed master slots for the CPU; other masters (DMA, debug) follow.
  localparam int BUS_MASTER_CPU_IF  = 0;
  localparam int BUS_MASTER_CPU_MEM = 1;

  // Default number of bus masters on the shared bus.
  localparam int NUM_MASTERS_DEF = 4;

  // Active-low request/grant levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_e;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector cyclically
// starting at start_i and returns the first requester not masked by
// excl_i. The scan wraps modulo N, so non-power-of-2 sizes never yield
// an out-of-range index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,     // active-high requests
  input  logic [W-1:0] start_i,   // first index to consider
  input  logic [N-1:0] excl_i,    // masters barred from this decision
  output logic [W-1:0] winner_o,
  output logic         valid_o
);

  // Cyclic priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before
    // any conditional assignment, otherwise synthesis infers a latch.
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] idx;
      idx = W'((int'(start_i) + k) % N);
      if (!valid_o && req_i[idx] && !excl_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus. Active-low requests in,
// registered one-hot-low grants out. A grant is held until its owner
// drops the request; on release the grant moves straight to the next
// requester (searching from owner+1) with no idle bubble.
//
// Optional feature, macro BUS_ARB_TIMEOUT_EN: a hold counter forcibly
// revokes a grant held for TIMEOUT_CYCLES cycles, pulses timeout_err and
// excludes the offender from that one re-arbitration. Without the macro
// grants are held indefinitely and timeout_err is tied low.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = NUM_MASTERS_DEF,
  parameter int OWNER_W        = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req_,
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  arb_state_e             state_q, state_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
  logic                   terr_q, terr_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] excl;
  logic [OWNER_W-1:0]     start_idx;
  logic [OWNER_W-1:0]     pick_idx;
  logic                   pick_vld;
  logic                   timeout_hit;

  // Picker inputs: active-high requests, search start owner+1 (mod N),
  // and the current owner masked out whenever a grant is being moved.
  always_comb begin
    req       = ~m_req_;
    start_idx = (owner_q == OWNER_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    excl      = '0;
    if (state_q == ARB_GRANTED) begin
      excl[owner_q] = 1'b1;
    end
  end

  // One picker serves both the IDLE grant and the GRANTED hand-over.
  rr_pick #(
    .N (NUM_MASTERS),
    .W (OWNER_W)
  ) u_rr_pick (
    .req_i    (req),
    .start_i  (start_idx),
    .excl_i   (excl),
    .winner_o (pick_idx),
    .valid_o  (pick_vld)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires in the last of TIMEOUT_CYCLES held cycles; the grant is
  // revoked at the following edge if the owner is still requesting.
  assign timeout_hit = (state_q == ARB_GRANTED) && req[owner_q] &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Hold counter: counts consecutive cycles of the same grant, restarts
  // on every new grant and whenever the bus goes idle.
  always_comb begin
    cnt_d = '0;
    if (state_q == ARB_GRANTED && state_d == ARB_GRANTED && grnt_d == grnt_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // Parameter kept for interface compatibility; unused in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state, owner and grant computation for the two-state FSM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grnt_d  = grnt_q;
    terr_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d          = ARB_GRANTED;
          owner_d          = pick_idx;
          grnt_d           = {NUM_MASTERS{DISABLE_}};
          grnt_d[pick_idx] = ENABLE_;
        end
      end
      ARB_GRANTED: begin
        // No preemption: other requests only matter once the owner lets
        // go or its hold time expires.
        if (!req[owner_q] || timeout_hit) begin
          terr_d = timeout_hit;
          if (pick_vld) begin
            owner_d          = pick_idx;
            grnt_d           = {NUM_MASTERS{DISABLE_}};
            grnt_d[pick_idx] = ENABLE_;
          end else begin
            state_d = ARB_IDLE;
            grnt_d  = {NUM_MASTERS{DISABLE_}};
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grnt_d  = {NUM_MASTERS{DISABLE_}};
      end
    endcase
  end

  // State, owner, grant and error-pulse registers; reset drops all
  // grants immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_W'(BUS_MASTER_CPU_IF);
      grnt_q  <= {NUM_MASTERS{DISABLE_}};
      terr_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples its pre-edge value regardless of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
      terr_q  <= terr_d;
    end
  end

  assign m_grnt_     = grnt_q;
  assign owner       = owner_q;
  assign bus_busy    = (state_q == ARB_GRANTED);
  assign timeout_err = terr_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (4 masters, TIMEOUT_CYCLES = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// that same point, well away from the next active edge.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int OW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  m_req_;
  logic [N-1:0]  m_grnt_;
  logic [OW-1:0] owner;
  logic          bus_busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .OWNER_W        (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_      (m_req_),
    .m_grnt_     (m_grnt_),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  // Expected active-low grant vector for master i.
  function automatic logic [N-1:0] grant_of(input int i);
    logic [N-1:0] g;
    g    = '1;
    g[i] = 1'b0;
    return g;
  endfunction

  // Apply reset for one edge with the given request pattern, then release
  // it 1 unit after an edge.
  task automatic do_reset(input logic [N-1:0] req);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    m_req_ = req;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'b0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner, bus_busy, timeout_err} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got grnt=%b owner=%0d busy=%b terr=%b, want grnt=1111 owner=0 busy=0 terr=0",
               m_grnt_, owner, bus_busy, timeout_err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner, bus_busy} !== {4'b1101, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_grant: got grnt=%b owner=%0d busy=%b, want grnt=1101 owner=1 busy=1",
               m_grnt_, owner, bus_busy);
    end
  endtask

  task automatic test_single_master();
    do_reset(4'b1111);
    m_req_ = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_grnt_, owner, bus_busy} !== {4'b1011, 2'd2, 1'b1}) begin
        errors++;
        $display("FAIL single_hold cyc %0d: got grnt=%b owner=%0d busy=%b, want grnt=1011 owner=2 busy=1",
                 c, m_grnt_, owner, bus_busy);
      end
    end
    m_req_ = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_grnt_, owner, bus_busy} !== {4'b1111, 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL single_release cyc %0d: got grnt=%b owner=%0d busy=%b, want grnt=1111 owner=2 busy=0",
                 c, m_grnt_, owner, bus_busy);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if ({m_grnt_, owner, bus_busy} !== {grant_of(exp_seq[i]), OW'(exp_seq[i]), 1'b1}) begin
          errors++;
          $display("FAIL round_robin slot %0d cyc %0d: got grnt=%b owner=%0d busy=%b, want grnt=%b owner=%0d busy=1",
                   i, c, m_grnt_, owner, bus_busy, grant_of(exp_seq[i]), exp_seq[i]);
        end
        if (c == 0 && i > 0) m_req_[exp_seq[i-1]] = 1'b0;
        if (c == 2) m_req_[exp_seq[i]] = 1'b1;
      end
    end
    m_req_ = 4'b1111;
  endtask

  task automatic test_handover();
    do_reset(4'b1110);
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner} !== {4'b1110, 2'd0}) begin
      errors++;
      $display("FAIL handover_setup: got grnt=%b owner=%0d, want grnt=1110 owner=0", m_grnt_, owner);
    end
    m_req_ = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_grnt_, owner, bus_busy} !== {4'b0111, 2'd3, 1'b1}) begin
        errors++;
        $display("FAIL handover cyc %0d: got grnt=%b owner=%0d busy=%b, want grnt=0111 owner=3 busy=1",
                 c, m_grnt_, owner, bus_busy);
      end
    end
    m_req_ = 4'b1111;
  endtask

  task automatic test_async_reset();
    do_reset(4'b1101);
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner} !== {4'b1101, 2'd1}) begin
      errors++;
      $display("FAIL async_setup: got grnt=%b owner=%0d, want grnt=1101 owner=1", m_grnt_, owner);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_grnt_, owner, bus_busy} !== {4'b1111, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got grnt=%b owner=%0d busy=%b, want grnt=1111 owner=0 busy=0",
               m_grnt_, owner, bus_busy);
    end
    m_req_ = 4'b1111;
    rst    = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset(4'b1001);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_grnt_, owner, timeout_err} !== {4'b1101, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL timeout_hold cyc %0d: got grnt=%b owner=%0d terr=%b, want grnt=1101 owner=1 terr=0",
                 c, m_grnt_, owner, timeout_err);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner, timeout_err} !== {4'b1011, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL timeout_revoke: got grnt=%b owner=%0d terr=%b, want grnt=1011 owner=2 terr=1",
               m_grnt_, owner, timeout_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m_grnt_, owner, timeout_err} !== {4'b1011, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_pulse_end: got grnt=%b owner=%0d terr=%b, want grnt=1011 owner=2 terr=0",
               m_grnt_, owner, timeout_err);
    end
`else
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({m_grnt_, owner, bus_busy, timeout_err} !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL no_timeout_hold cyc %0d: got grnt=%b owner=%0d busy=%b terr=%b, want grnt=1101 owner=1 busy=1 terr=0",
                 c, m_grnt_, owner, bus_busy, timeout_err);
      end
    end
`endif
    m_req_ = 4'b1111;
  endtask

  initial begin
    rst    = 1'b1;
    m_req_ = 4'b1111;
    test_reset();
    test_single_master();
    test_round_robin();
    test_handover();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_arbiter
